fetch_unit: RTL

- IF-stage producer feeding the IF/ID pipeline register with InstrF, PCF and PCPlus4F.
- Owns the PC register and a single-outstanding-request handshake to instruction memory.
- Holds its output under stall and redirects on branch/jump resolved in EX.
- Emits NOP bubbles while memory is pending or after a redirect squash.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_pc_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: datapath width, reset/NOP
// defaults, the fetch FSM state type and a word-alignment helper.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReq,      // request presented to memory
        StWait,     // request accepted, waiting for response
        StHave,     // valid instruction held for the decode stage
        StDiscard   // response still owed but already squashed
    } fetch_state_e;

    // RV32I without compressed instructions: targets are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle.
//   imem_req    fetch -> mem  request valid
//   imem_addr   fetch -> mem  request address
//   imem_ready  mem -> fetch  request accepted this cycle
//   imem_rvalid mem -> fetch  response valid
//   imem_rdata  mem -> fetch  response instruction word
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with load / increment-by-4 / hold.
//   clk, reset  clock and asynchronous active-high reset (loads RESET_PC)
//   load_i      load load_val_i (takes priority over incr_i)
//   load_val_i  value to load
//   incr_i      advance by 4, wrapping modulo 2^XLEN
//   pc_o        current PC
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (incr_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the PC, issues one outstanding instruction-memory
// request at a time and presents InstrF/PCF/PCPlus4F to the IF/ID register.
//   clk, reset  clock and asynchronous active-high reset
//   StallF      hold the currently presented instruction
//   PCSrcE      redirect from EX to PCTargetE
//   PCTargetE   redirect target (low two bits ignored)
//   imem        instruction-memory request/response (master side)
//   InstrF      fetched instruction, NOP_INSTR when ValidF=0
//   PCF         PC of InstrF (the PC register)
//   PCPlus4F    PCF + 4, wrapping
//   ValidF      InstrF is a real fetched instruction
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallF,
    input  logic                PCSrcE,
    input  logic [XLEN-1:0]     PCTargetE,
    fetch_unit_if.master        imem,
    output logic [XLEN-1:0]     InstrF,
    output logic [XLEN-1:0]     PCF,
    output logic [XLEN-1:0]     PCPlus4F,
    output logic                ValidF
);

    fetch_state_e    state_d, state_q;
    logic [XLEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pc;
    logic            pc_load;
    logic            pc_incr;

    fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (align_word(PCTargetE)),
        .incr_i     (pc_incr),
        .pc_o       (pc)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;
        pc_incr = 1'b0;
        case (state_q)
            StReq: begin
                if (PCSrcE) begin
                    pc_load = 1'b1;
                    // Request at the old PC was accepted in the same cycle as
                    // the redirect: its response is still owed and must be dropped.
                    if (imem.imem_ready) begin
                        state_d = StDiscard;
                    end
                end else if (imem.imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (PCSrcE) begin
                    pc_load = 1'b1;
                    state_d = imem.imem_rvalid ? StReq : StDiscard;
                end else if (imem.imem_rvalid) begin
                    instr_d = imem.imem_rdata;
                    state_d = StHave;
                end
            end
            StDiscard: begin
                if (PCSrcE) begin
                    pc_load = 1'b1;
                end
                if (imem.imem_rvalid) begin
                    state_d = StReq;
                end
            end
            StHave: begin
                // Redirect beats stall: the held instruction is on the wrong path.
                if (PCSrcE) begin
                    pc_load = 1'b1;
                    state_d = StReq;
                end else if (!StallF) begin
                    pc_incr = 1'b1;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReq;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign imem.imem_req  = (state_q == StReq) && !reset;
    assign imem.imem_addr = pc;

    assign ValidF   = (state_q == StHave);
    assign InstrF   = ValidF ? instr_q : NOP_INSTR;
    assign PCF      = pc;
    assign PCPlus4F = pc + XLEN'(4);

    // A response is only legal while one is owed.
    a_rvalid_owed: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rvalid |-> (state_q inside {StWait, StDiscard}));

endmodule
